// File: rtl/issue_queue.sv
// issue_queue: circular FIFO between decode and issue; define IQ_BYPASS_EN to let an empty queue pass entries straight through
module issue_queue #(
  parameter int DEPTH = 8,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     stall_in,
  input  logic                     flush_in,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic                     stall_from_issue,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic full, empty, push, pop, wr_en, rd_en;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign stall_from_issue = full;
  assign push = in_valid && !stall_in && !full && !flush_in;
  assign pop = out_valid && out_ready && !flush_in;
`ifdef IQ_BYPASS_EN
  assign out_valid = empty ? in_valid && !stall_in : 1'b1;
  assign out_data = empty ? in_data : mem[rd_ptr];
  assign wr_en = push && !(empty && out_ready);
  assign rd_en = pop && !empty;
`else
  assign out_valid = !empty;
  assign out_data = mem[rd_ptr];
  assign wr_en = push;
  assign rd_en = pop;
`endif
  // entry storage is never cleared; only slots between the pointers are ever visible
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= in_data;
  // pointer and occupancy tracking; flush outranks any push or pop in the same cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr + AW'(rd_en);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: randomized and directed checks of issue_queue against a queue-based reference model
module tb_issue_queue;
  localparam int DEPTH = 8;
  localparam int DW = 64;
  logic clk = 0;
  logic rst_n = 0;
  logic in_valid = 0;
  logic stall_in = 0;
  logic flush_in = 0;
  logic out_ready = 0;
  logic [DW-1:0] in_data = '0;
  logic out_valid, stall_from_issue;
  logic [DW-1:0] out_data;
  logic [3:0] count;
  int nchk = 0;
  int nfail = 0;
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_pop[$];
  logic [DW-1:0] obs_pop[$];

  always #5 clk = ~clk;

  issue_queue #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .stall_in(stall_in), .flush_in(flush_in), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready),
    .stall_from_issue(stall_from_issue), .count(count)
  );

  function automatic logic [DW-1:0] rnd();
    return {$urandom(), $urandom()};
  endfunction

  task automatic idle();
    in_valid = 0;
    in_data = '0;
    stall_in = 0;
    flush_in = 0;
    out_ready = 0;
  endtask

  // drive one cycle, advance the reference model, return at posedge+1
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic s, input logic f, input logic r);
    bit full_m, push_m;
    in_valid = v;
    in_data = d;
    stall_in = s;
    flush_in = f;
    out_ready = r;
    #1;
    if (out_valid && out_ready && !flush_in) obs_pop.push_back(out_data);
    if (f) mq.delete();
    else begin
      full_m = mq.size() == DEPTH;
      push_m = v && !s && !full_m;
      if (mq.size() == 0) begin
`ifdef IQ_BYPASS_EN
        if (push_m && r) begin
          exp_pop.push_back(d);
          push_m = 0;
        end
`endif
      end else if (r) exp_pop.push_back(mq.pop_front());
      if (push_m) mq.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    while (mq.size() != 0) cycle(0, '0, 0, 0, 1);
    idle();
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    @(posedge clk);
    #1;
    nchk++; if (count !== 4'd0) begin nfail++; $display("FAIL reset_count got %0d want 0", count); end
    nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    nchk++; if (stall_from_issue !== 1'b0) begin nfail++; $display("FAIL reset_stall got %b want 0", stall_from_issue); end
    rst_n = 1;
    mq.delete(); exp_pop.delete(); obs_pop.delete();
  endtask

  task automatic test_push3();
    cycle(1, 'h11, 0, 0, 0);
    cycle(1, 'h22, 0, 0, 0);
    cycle(1, 'h33, 0, 0, 0);
    nchk++; if (count !== 4'd3) begin nfail++; $display("FAIL push3_count got %0d want 3", count); end
    nchk++; if (out_data !== 64'h11) begin nfail++; $display("FAIL push3_head got %h want 11", out_data); end
    nchk++; if (stall_from_issue !== 1'b0) begin nfail++; $display("FAIL push3_stall got %b want 0", stall_from_issue); end
    nchk++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL push3_out_valid got %b want 1", out_valid); end
  endtask

  task automatic test_full();
    for (int k = 4; k <= 8; k++) cycle(1, 64'(k * 'h11), 0, 0, 0);
    nchk++; if (count !== 4'd8) begin nfail++; $display("FAIL full_count got %0d want 8", count); end
    nchk++; if (stall_from_issue !== 1'b1) begin nfail++; $display("FAIL full_stall got %b want 1", stall_from_issue); end
    cycle(1, 'h99, 0, 0, 0);
    nchk++; if (count !== 4'd8) begin nfail++; $display("FAIL full_drop_count got %0d want 8", count); end
    cycle(1, 'h9A, 0, 0, 1);
    nchk++; if (count !== 4'd7) begin nfail++; $display("FAIL full_pop_nopush_count got %0d want 7", count); end
    nchk++; if (stall_from_issue !== 1'b0) begin nfail++; $display("FAIL full_pop_stall got %b want 0", stall_from_issue); end
    cycle(1, 'h9B, 1, 0, 0);
    nchk++; if (count !== 4'd7) begin nfail++; $display("FAIL stall_in_count got %0d want 7", count); end
    drain();
    nchk++; if (count !== 4'd0) begin nfail++; $display("FAIL full_drain_count got %0d want 0", count); end
    nchk++; if (obs_pop.size() != 8) begin nfail++; $display("FAIL full_pop_len got %0d want 8", obs_pop.size()); end
    for (int i = 0; i < obs_pop.size() && i < 8; i++) begin
      nchk++; if (obs_pop[i] !== 64'((i + 1) * 'h11)) begin nfail++; $display("FAIL full_order[%0d] got %h want %h", i, obs_pop[i], 64'((i + 1) * 'h11)); end
    end
    exp_pop.delete(); obs_pop.delete();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) cycle(1, rnd(), 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, rnd(), 0, 0, 1);
      nchk++; if (count !== 4'd4) begin nfail++; $display("FAIL b2b_count[%0d] got %0d want 4", i, count); end
    end
    drain();
    nchk++; if (obs_pop.size() != exp_pop.size()) begin nfail++; $display("FAIL b2b_len got %0d want %0d", obs_pop.size(), exp_pop.size()); end
    for (int i = 0; i < obs_pop.size() && i < exp_pop.size(); i++) begin
      nchk++; if (obs_pop[i] !== exp_pop[i]) begin nfail++; $display("FAIL b2b_order[%0d] got %h want %h", i, obs_pop[i], exp_pop[i]); end
    end
    exp_pop.delete(); obs_pop.delete();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) cycle(1, rnd(), 0, 0, 0);
    cycle(1, rnd(), 0, 1, 1);
    idle();
    #1;
    nchk++; if (count !== 4'd0) begin nfail++; $display("FAIL flush_count got %0d want 0", count); end
    nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
    for (int i = 0; i < 8; i++) cycle(1, rnd(), 0, 0, 0);
    cycle(0, '0, 0, 1, 0);
    nchk++; if (stall_from_issue !== 1'b0) begin nfail++; $display("FAIL flush_full_stall got %b want 0", stall_from_issue); end
    cycle(1, 'hC3, 0, 0, 0);
    nchk++; if (out_data !== 64'hC3) begin nfail++; $display("FAIL flush_next_head got %h want c3", out_data); end
    nchk++; if (count !== 4'd1) begin nfail++; $display("FAIL flush_next_count got %0d want 1", count); end
    drain();
    exp_pop.delete(); obs_pop.delete();
  endtask

  task automatic test_async_reset();
    while (mq.size() < 6) cycle(1, rnd(), 0, 0, 0);
    in_valid = 1;
    in_data = rnd();
    out_ready = 0;
    #2;
    rst_n = 0;
    #1;
    nchk++; if (count !== 4'd0) begin nfail++; $display("FAIL arst_count got %0d want 0", count); end
    nchk++; if (stall_from_issue !== 1'b0) begin nfail++; $display("FAIL arst_stall got %b want 0", stall_from_issue); end
    in_valid = 0;
    #1;
    rst_n = 1;
    mq.delete(); exp_pop.delete(); obs_pop.delete();
    @(posedge clk);
    #1;
    cycle(1, 'hAB, 0, 0, 0);
    nchk++; if (out_data !== 64'hAB) begin nfail++; $display("FAIL arst_head got %h want ab", out_data); end
    nchk++; if (count !== 4'd1) begin nfail++; $display("FAIL arst_next_count got %0d want 1", count); end
    drain();
    exp_pop.delete(); obs_pop.delete();
  endtask

  task automatic test_bypass();
    in_valid = 1;
    in_data = 'h5A;
    out_ready = 1;
    #1;
`ifdef IQ_BYPASS_EN
    nchk++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL byp_same_valid got %b want 1", out_valid); end
    nchk++; if (out_data !== 64'h5A) begin nfail++; $display("FAIL byp_same_data got %h want 5a", out_data); end
`else
    nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL byp_same_valid got %b want 0", out_valid); end
`endif
    cycle(1, 'h5A, 0, 0, 1);
    idle();
    #1;
`ifdef IQ_BYPASS_EN
    nchk++; if (count !== 4'd0) begin nfail++; $display("FAIL byp_count got %0d want 0", count); end
    nchk++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL byp_next_valid got %b want 0", out_valid); end
`else
    nchk++; if (count !== 4'd1) begin nfail++; $display("FAIL byp_count got %0d want 1", count); end
    nchk++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL byp_next_valid got %b want 1", out_valid); end
    nchk++; if (out_data !== 64'h5A) begin nfail++; $display("FAIL byp_next_data got %h want 5a", out_data); end
`endif
    drain();
    exp_pop.delete(); obs_pop.delete();
  endtask

  task automatic test_random();
    bit ev;
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 5) == 0,
            $urandom_range(0, 40) == 0, $urandom_range(0, 3) < (i < 200 ? 1 : 3));
      ev = mq.size() != 0;
`ifdef IQ_BYPASS_EN
      if (mq.size() == 0) ev = in_valid && !stall_in;
`endif
      nchk++; if (count !== 4'(mq.size())) begin nfail++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, count, mq.size()); end
      nchk++; if (stall_from_issue !== (mq.size() == DEPTH)) begin nfail++; $display("FAIL rnd_stall[%0d] got %b want %b", i, stall_from_issue, mq.size() == DEPTH); end
      nchk++; if (out_valid !== ev) begin nfail++; $display("FAIL rnd_out_valid[%0d] got %b want %b", i, out_valid, ev); end
      if (mq.size() != 0) begin
        nchk++; if (out_data !== mq[0]) begin nfail++; $display("FAIL rnd_head[%0d] got %h want %h", i, out_data, mq[0]); end
      end
    end
    drain();
    nchk++; if (obs_pop.size() != exp_pop.size()) begin nfail++; $display("FAIL rnd_len got %0d want %0d", obs_pop.size(), exp_pop.size()); end
    for (int i = 0; i < obs_pop.size() && i < exp_pop.size(); i++) begin
      nchk++; if (obs_pop[i] !== exp_pop[i]) begin nfail++; $display("FAIL rnd_order[%0d] got %h want %h", i, obs_pop[i], exp_pop[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_push3();
    test_full();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
